// File: rtl/key_dispatcher.sv
// key_dispatcher: hands out contiguous RC4 key blocks to idle arcfour cores
// through a round-robin arbiter, stops on the first reported hit and
// reports failure once the key space is exhausted and every core is idle.
// Optional build macro KEY_DISPATCH_STATS_EN enables the blocks_issued
// counter; without it blocks_issued is tied to zero.
module key_dispatcher #(
  parameter int unsigned          NUM_CORES      = 8,
  parameter int unsigned          LOG_NUM_CORES  = 3,
  parameter int unsigned          KEY_WIDTH      = 24,
  parameter int unsigned          LOG_BLOCK_SIZE = 8,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX        = 24'hffffff
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES-1:0]           busy,
  input  logic [NUM_CORES-1:0]           found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] found_key,
  output logic [NUM_CORES-1:0]           grant,
  output logic [KEY_WIDTH-1:0]           grant_base,
  output logic [KEY_WIDTH-1:0]           grant_last,
  output logic                           running,
  output logic                           success,
  output logic                           fail,
  output logic [KEY_WIDTH-1:0]           result_key,
  output logic [LOG_NUM_CORES-1:0]       result_core,
  output logic [KEY_WIDTH-1:0]           blocks_issued
);

  // Block arithmetic is one bit wider than a key so the counter cannot wrap.
  localparam logic [KEY_WIDTH:0] BLK       = (KEY_WIDTH+1)'(1) << LOG_BLOCK_SIZE;
  localparam logic [KEY_WIDTH:0] KEY_MAX_X = {1'b0, KEY_MAX};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_SUCCESS,
    S_FAIL
  } state_t;

  state_t                   state;
  logic [KEY_WIDTH:0]       next_base;
  logic [LOG_NUM_CORES-1:0] rr_ptr;

  logic [NUM_CORES-1:0]     elig;
  logic [NUM_CORES-1:0]     rot;
  logic                     pick_valid;
  logic [LOG_NUM_CORES:0]   pick_off;
  logic [LOG_NUM_CORES:0]   pick_sum;
  logic [LOG_NUM_CORES-1:0] pick_idx;
  logic [LOG_NUM_CORES-1:0] rr_next;
  logic                     fnd_valid;
  logic [LOG_NUM_CORES-1:0] fnd_idx;
  logic [KEY_WIDTH-1:0]     fnd_key;
  logic [KEY_WIDTH:0]       blk_end;
  logic [KEY_WIDTH:0]       blk_last;

  // Round-robin pick: rotate eligible requests so rr_ptr lands on bit 0,
  // take the lowest set bit, then map the offset back to a core index.
  always_comb begin
    elig       = req & ~grant;
    rot        = NUM_CORES'({elig, elig} >> rr_ptr);
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!pick_valid && rot[i]) begin
        pick_valid = 1'b1;
        pick_off   = (LOG_NUM_CORES+1)'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr} + pick_off;
    if (pick_sum >= (LOG_NUM_CORES+1)'(NUM_CORES))
      pick_sum = pick_sum - (LOG_NUM_CORES+1)'(NUM_CORES);
    pick_idx = pick_sum[LOG_NUM_CORES-1:0];
    rr_next  = (pick_idx == LOG_NUM_CORES'(NUM_CORES - 1)) ? '0
                                                           : pick_idx + LOG_NUM_CORES'(1);
  end

  // Lowest-index success report wins when several cores hit together.
  always_comb begin
    fnd_valid = 1'b0;
    fnd_idx   = '0;
    fnd_key   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!fnd_valid && found[i]) begin
        fnd_valid = 1'b1;
        fnd_idx   = LOG_NUM_CORES'(i);
        fnd_key   = found_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  // Last key of the block being offered, clamped to the end of the key space.
  always_comb begin
    blk_end  = next_base + BLK - (KEY_WIDTH+1)'(1);
    blk_last = (blk_end > KEY_MAX_X) ? KEY_MAX_X : blk_end;
  end

  // Control FSM with all status and grant outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      next_base   <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_base  <= '0;
      grant_last  <= '0;
      running     <= 1'b0;
      success     <= 1'b0;
      fail        <= 1'b0;
      result_key  <= '0;
      result_core <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      next_base <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      running   <= 1'b0;
      success   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        S_IDLE: begin
          next_base <= '0;
          rr_ptr    <= '0;
          if (start) begin
            state       <= S_DISPATCH;
            running     <= 1'b1;
            result_key  <= '0;
            result_core <= '0;
          end
        end
        S_DISPATCH: begin
          if (fnd_valid) begin
            state       <= S_SUCCESS;
            running     <= 1'b0;
            success     <= 1'b1;
            result_key  <= fnd_key;
            result_core <= fnd_idx;
          end else if (pick_valid) begin
            grant      <= NUM_CORES'(1) << pick_idx;
            grant_base <= next_base[KEY_WIDTH-1:0];
            grant_last <= blk_last[KEY_WIDTH-1:0];
            next_base  <= next_base + BLK;
            rr_ptr     <= rr_next;
            if (blk_last == KEY_MAX_X)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fnd_valid) begin
            state       <= S_SUCCESS;
            running     <= 1'b0;
            success     <= 1'b1;
            result_key  <= fnd_key;
            result_core <= fnd_idx;
          end else if (busy == '0 && grant == '0) begin
            // A grant issued last cycle has not raised busy yet; wait for it.
            state   <= S_FAIL;
            running <= 1'b0;
            fail    <= 1'b1;
          end
        end
        S_SUCCESS, S_FAIL: begin
          if (start) begin
            state       <= S_DISPATCH;
            running     <= 1'b1;
            success     <= 1'b0;
            fail        <= 1'b0;
            next_base   <= '0;
            rr_ptr      <= '0;
            result_key  <= '0;
            result_core <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEY_DISPATCH_STATS_EN
  logic issue;
  logic start_accept;

  always_comb begin
    issue        = !abort && (state == S_DISPATCH) && !fnd_valid && pick_valid;
    start_accept = !abort && start &&
                   (state == S_IDLE || state == S_SUCCESS || state == S_FAIL);
  end

  // Saturating count of grants issued since the last start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      blocks_issued <= '0;
    else if (start_accept)
      blocks_issued <= '0;
    else if (issue && blocks_issued != '1)
      blocks_issued <= blocks_issued + KEY_WIDTH'(1);
  end
`else
  assign blocks_issued = '0;
`endif

endmodule

// File: tb/tb_key_dispatcher.sv
// Self-checking bench for key_dispatcher: 4 cores, 16-key blocks. Instance A
// covers keys 0x00..0x3F, instance B ends on a short block at 0x35.
module tb_key_dispatcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  req;
  logic [3:0]  busy;
  logic [3:0]  found;
  logic [95:0] found_key;

  logic [3:0]  grant_a, grant_b;
  logic [23:0] grant_base_a, grant_base_b, grant_last_a, grant_last_b;
  logic        running_a, running_b, success_a, success_b, fail_a, fail_b;
  logic [23:0] result_key_a, result_key_b;
  logic [1:0]  result_core_a, result_core_b;
  logic [23:0] blocks_issued_a, blocks_issued_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  g;
    logic [23:0] base;
    logic [23:0] last;
  } exp_t;

  exp_t q[$];

`ifdef KEY_DISPATCH_STATS_EN
  localparam logic [23:0] EXP_BLOCKS = 24'd4;
`else
  localparam logic [23:0] EXP_BLOCKS = 24'd0;
`endif

  key_dispatcher #(
    .NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24),
    .LOG_BLOCK_SIZE(4), .KEY_MAX(24'h00003F)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .req(req), .busy(busy), .found(found), .found_key(found_key),
    .grant(grant_a), .grant_base(grant_base_a), .grant_last(grant_last_a),
    .running(running_a), .success(success_a), .fail(fail_a),
    .result_key(result_key_a), .result_core(result_core_a),
    .blocks_issued(blocks_issued_a)
  );

  key_dispatcher #(
    .NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24),
    .LOG_BLOCK_SIZE(4), .KEY_MAX(24'h000035)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .req(req), .busy(busy), .found(found), .found_key(found_key),
    .grant(grant_b), .grant_base(grant_base_b), .grant_last(grant_last_b),
    .running(running_b), .success(success_b), .fail(fail_b),
    .result_key(result_key_b), .result_core(result_core_b),
    .blocks_issued(blocks_issued_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] g, input logic [23:0] b, input logic [23:0] l);
    exp_t e;
    e.g = g; e.base = b; e.last = l;
    return e;
  endfunction

  // Abort whatever is running on both instances, then pulse start.
  task automatic start_search(input logic [3:0] r);
    @(negedge clk);
    abort = 1'b1; found = '0; busy = '0; req = '0;
    @(negedge clk);
    abort = 1'b0; start = 1'b1; req = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    req = '0; busy = '0; found = '0; found_key = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant_a, grant_base_a, grant_last_a} !== '0) begin
      errors++;
      $display("FAIL reset_grant_a: got %h/%h/%h want 0/0/0", grant_a, grant_base_a, grant_last_a);
    end
    checks++;
    if ({running_a, success_a, fail_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags_a: got %b want 000", {running_a, success_a, fail_a});
    end
    checks++;
    if ({result_key_a, result_core_a, blocks_issued_a} !== '0) begin
      errors++;
      $display("FAIL reset_results_a: got %h/%h/%h want 0", result_key_a, result_core_a, blocks_issued_a);
    end
    checks++;
    if ({grant_b, grant_base_b, grant_last_b, running_b, success_b, fail_b,
         result_key_b, result_core_b, blocks_issued_b} !== '0) begin
      errors++;
      $display("FAIL reset_all_b: some output of instance B nonzero");
    end
    reset = 1'b1;
  endtask

  task automatic test_full_sweep;
    q.delete();
    q.push_back(mk(4'b0001, 24'h00, 24'h0F));
    q.push_back(mk(4'b0010, 24'h10, 24'h1F));
    q.push_back(mk(4'b0100, 24'h20, 24'h2F));
    q.push_back(mk(4'b1000, 24'h30, 24'h3F));
    start_search(4'hF);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (grant_a != '0) begin
        exp_t e = q.pop_front();
        checks++;
        if (grant_a !== e.g) begin
          errors++; $display("FAIL sweep_grant: got %b want %b", grant_a, e.g);
        end
        checks++;
        if (grant_base_a !== e.base) begin
          errors++; $display("FAIL sweep_base: got %h want %h", grant_base_a, e.base);
        end
        checks++;
        if (grant_last_a !== e.last) begin
          errors++; $display("FAIL sweep_last: got %h want %h", grant_last_a, e.last);
        end
        req  = req & ~grant_a;
        busy = busy | grant_a;
      end
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL sweep_timeout: %0d grants missing, want 0", q.size());
    end
    @(negedge clk);
    checks++;
    if ({running_a, fail_a, grant_a} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL sweep_drain: running/fail/grant got %b/%b/%b want 1/0/0000", running_a, fail_a, grant_a);
    end
    busy = '0;
    @(negedge clk);
    checks++;
    if ({fail_a, running_a, success_a} !== 3'b100) begin
      errors++;
      $display("FAIL sweep_fail: fail/running/success got %b want 100", {fail_a, running_a, success_a});
    end
    checks++;
    if (blocks_issued_a !== EXP_BLOCKS) begin
      errors++; $display("FAIL sweep_blocks: got %0d want %0d", blocks_issued_a, EXP_BLOCKS);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] prev_g;
    prev_g = '0;
    q.delete();
    q.push_back(mk(4'b0010, 24'h00, 24'h0F));
    q.push_back(mk(4'b1000, 24'h10, 24'h1F));
    q.push_back(mk(4'b0010, 24'h20, 24'h2F));
    q.push_back(mk(4'b1000, 24'h30, 24'h3F));
    start_search(4'b1010);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (grant_a != '0) begin
        exp_t e = q.pop_front();
        checks++;
        if (grant_a !== e.g) begin
          errors++; $display("FAIL rr_grant: got %b want %b", grant_a, e.g);
        end
        checks++;
        if (grant_base_a !== e.base) begin
          errors++; $display("FAIL rr_base: got %h want %h", grant_base_a, e.base);
        end
        checks++;
        if (grant_a === prev_g) begin
          errors++; $display("FAIL rr_repeat: core mask %b granted twice in a row, want alternation", grant_a);
        end
      end
      prev_g = grant_a;
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL rr_timeout: %0d grants missing, want 0", q.size());
    end
    req = '0;
  endtask

  task automatic test_found_same_cycle;
    start_search(4'b0000);
    found_key = {24'h0, 24'h25, 24'h0, 24'h07};
    found = 4'b0101;
    req   = 4'hF;
    @(negedge clk);
    found = '0;
    checks++;
    if ({success_a, running_a} !== 2'b10) begin
      errors++; $display("FAIL found_flags: success/running got %b want 10", {success_a, running_a});
    end
    checks++;
    if (result_core_a !== 2'd0) begin
      errors++; $display("FAIL found_core: got %0d want 0", result_core_a);
    end
    checks++;
    if (result_key_a !== 24'h07) begin
      errors++; $display("FAIL found_key: got %h want 000007", result_key_a);
    end
    checks++;
    if (grant_a !== 4'b0000) begin
      errors++; $display("FAIL found_nogrant: got %b want 0000", grant_a);
    end
    found_key = {24'h0, 24'h0, 24'h99, 24'h0};
    found = 4'b0010;
    @(negedge clk);
    found = '0;
    checks++;
    if ({result_core_a, result_key_a} !== {2'd0, 24'h07}) begin
      errors++; $display("FAIL found_hold: got %0d/%h want 0/000007", result_core_a, result_key_a);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({running_a, success_a, result_key_a} !== {1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL found_restart: running/success/key got %b/%b/%h want 1/0/000000", running_a, success_a, result_key_a);
    end
    req = '0;
  endtask

  task automatic test_short_block;
    int extra;
    q.delete();
    q.push_back(mk(4'b0001, 24'h00, 24'h0F));
    q.push_back(mk(4'b0010, 24'h10, 24'h1F));
    q.push_back(mk(4'b0100, 24'h20, 24'h2F));
    q.push_back(mk(4'b1000, 24'h30, 24'h35));
    start_search(4'hF);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (grant_b != '0) begin
        exp_t e = q.pop_front();
        checks++;
        if (grant_b !== e.g) begin
          errors++; $display("FAIL short_grant: got %b want %b", grant_b, e.g);
        end
        checks++;
        if (grant_base_b !== e.base) begin
          errors++; $display("FAIL short_base: got %h want %h", grant_base_b, e.base);
        end
        checks++;
        if (grant_last_b !== e.last) begin
          errors++; $display("FAIL short_last: got %h want %h", grant_last_b, e.last);
        end
        req  = req & ~grant_b;
        busy = busy | grant_b;
      end
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL short_timeout: %0d grants missing, want 0", q.size());
    end
    req = 4'hF;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (grant_b != '0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL short_extra: %0d grants after final block, want 0", extra);
    end
    req = '0;
  endtask

  task automatic test_abort_restart;
    q.delete();
    q.push_back(mk(4'b0001, 24'h00, 24'h0F));
    q.push_back(mk(4'b0010, 24'h10, 24'h1F));
    start_search(4'hF);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (grant_a != '0) begin
        exp_t e = q.pop_front();
        checks++;
        if (grant_base_a !== e.base) begin
          errors++; $display("FAIL abort_pre_base: got %h want %h", grant_base_a, e.base);
        end
        req = req & ~grant_a;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({running_a, grant_a} !== {1'b0, 4'b0000}) begin
      errors++; $display("FAIL abort_idle: running/grant got %b/%b want 0/0000", running_a, grant_a);
    end
    q.delete();
    q.push_back(mk(4'b0001, 24'h00, 24'h0F));
    req   = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (grant_a != '0) begin
        exp_t e = q.pop_front();
        checks++;
        if ({grant_a, grant_base_a, grant_last_a} !== {e.g, e.base, e.last}) begin
          errors++;
          $display("FAIL abort_restart: got %b/%h/%h want %b/%h/%h",
                   grant_a, grant_base_a, grant_last_a, e.g, e.base, e.last);
        end
        req = req & ~grant_a;
      end
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL abort_timeout: %0d grants missing, want 0", q.size());
    end
    req = '0;
  endtask

  task automatic test_async_reset;
    start_search(4'hF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({grant_a, grant_base_a, grant_last_a} !== '0) begin
      errors++; $display("FAIL async_grant: got %h/%h/%h want 0/0/0", grant_a, grant_base_a, grant_last_a);
    end
    checks++;
    if ({running_a, success_a, fail_a, result_key_a, result_core_a, blocks_issued_a} !== '0) begin
      errors++;
      $display("FAIL async_status: running %b blocks %0d want 0/0", running_a, blocks_issued_a);
    end
    @(negedge clk);
    reset = 1'b1;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_round_robin();
    test_found_same_cycle();
    test_short_block();
    test_abort_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
